// File: rtl/valrdy_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// valrdy_rr_arbiter_if
//   Bundles the val/rdy signals of the round-robin arbiter: the p_nreqs
//   requester streams on the input side and the single merged stream on the
//   output side.
//
//   Signals
//     req_val  [p_nreqs]          per-requester valid
//     req_rdy  [p_nreqs]          per-requester ready (from arbiter)
//     req_msg  [p_nreqs*p_width]  requester i at [i*p_width +: p_width]
//     out_val                     merged stream valid (from arbiter)
//     out_rdy                     downstream ready
//     out_msg  [p_width]          merged stream message (from arbiter)
//     out_src  [clog2(p_nreqs)]   index of the requester that sent out_msg
//     done                        all messages delivered (from arbiter)
//
//   Modports
//     master : the arbiter side (drives ready, output stream and done)
//     slave  : the harness side (drives valids, messages and out_rdy)
// ----------------------------------------------------------------------------
interface valrdy_rr_arbiter_if #(
    parameter int p_width = 16,
    parameter int p_nreqs = 4
);
    localparam int SW = (p_nreqs > 1) ? $clog2(p_nreqs) : 1;

    logic [p_nreqs-1:0]         req_val;
    logic [p_nreqs-1:0]         req_rdy;
    logic [p_nreqs*p_width-1:0] req_msg;
    logic                       out_val;
    logic                       out_rdy;
    logic [p_width-1:0]         out_msg;
    logic [SW-1:0]              out_src;
    logic                       done;

    modport master (
        input  req_val, req_msg, out_rdy,
        output req_rdy, out_val, out_msg, out_src, done
    );

    modport slave (
        output req_val, req_msg, out_rdy,
        input  req_rdy, out_val, out_msg, out_src, done
    );
endinterface

// File: rtl/valrdy_rr_arbiter.sv
// ----------------------------------------------------------------------------
// valrdy_rr_arbiter
//   Round-robin merge of p_nreqs val/rdy streams into one registered val/rdy
//   stream. One requester is granted per cycle; the accepted message is held
//   in a one-entry output buffer tagged with the requester index. After
//   p_nmsgs accepts no further requests are taken, and done rises once all
//   p_nmsgs messages have been handed downstream.
//
//   Ports
//     clk        clock, all state updates on the rising edge
//     reset      asynchronous active-low reset
//     bus        valrdy_rr_arbiter_if.master (requester and output streams)
//     grant_cnt  [p_nreqs*16] per-requester accept counters (optional)
//
//   Optional feature
//     VALRDY_RR_ARBITER_CNT_EN : when defined, adds grant_cnt with one
//     saturating 16-bit accept counter per requester.
// ----------------------------------------------------------------------------
module valrdy_rr_arbiter #(
    parameter int p_width = 16,
    parameter int p_nreqs = 4,
    parameter int p_nmsgs = 100
) (
    input  logic                   clk,
    input  logic                   reset,
    valrdy_rr_arbiter_if.master    bus
`ifdef VALRDY_RR_ARBITER_CNT_EN
    ,
    output logic [p_nreqs*16-1:0]  grant_cnt
`endif
);
    localparam int            SW      = (p_nreqs > 1) ? $clog2(p_nreqs) : 1;
    localparam int            CW      = $clog2(p_nmsgs + 1);
    localparam logic [CW-1:0] NMSGS   = CW'(p_nmsgs);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [SW-1:0] PTR_ONE = SW'(1);
    localparam logic [SW-1:0] LAST    = SW'(p_nreqs - 1);

    logic [SW-1:0]      r_ptr;
    logic               r_out_val;
    logic [p_width-1:0] r_out_msg;
    logic [SW-1:0]      r_out_src;
    logic [CW-1:0]      r_acc_cnt;
    logic [CW-1:0]      r_del_cnt;
    logic               r_done;

    logic               w_found;
    logic [SW-1:0]      w_grant_idx;
    logic [p_nreqs-1:0] w_grant_oh;
    logic [p_nreqs-1:0] w_req_rdy;
    logic [p_width-1:0] w_grant_msg;
    logic               w_space;
    logic               w_open;
    logic               w_accept;
    logic               w_deliver;

    // Search starts at the priority pointer and wraps; first valid wins.
    always_comb begin
        int            idx;
        logic [SW-1:0] cand;
        idx         = 0;
        cand        = '0;
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < p_nreqs; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= p_nreqs) begin
                idx = idx - p_nreqs;
            end
            cand = SW'(idx);
            if (!w_found && bus.req_val[cand]) begin
                w_found     = 1'b1;
                w_grant_idx = cand;
            end
        end
    end

    always_comb begin
        w_grant_msg = '0;
        for (int k = 0; k < p_nreqs; k++) begin
            if (w_grant_idx == SW'(k)) begin
                w_grant_msg = bus.req_msg[k*p_width +: p_width];
            end
        end
    end

    // The buffer can take a new message if empty or draining this cycle.
    assign w_space = !r_out_val || bus.out_rdy;
    assign w_open  = (r_acc_cnt != NMSGS);

    // Gating with reset keeps every ready low while reset is held, even
    // though the grant logic itself is purely combinational.
    for (genvar gi = 0; gi < p_nreqs; gi++) begin : g_rdy
        assign w_grant_oh[gi] = w_found && (w_grant_idx == SW'(gi));
        assign w_req_rdy[gi]  = w_grant_oh[gi] && w_space && w_open && reset;
    end

    assign w_accept  = |(bus.req_val & w_req_rdy);
    assign w_deliver = r_out_val && bus.out_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr     <= '0;
            r_out_val <= 1'b0;
            r_out_msg <= '0;
            r_out_src <= '0;
            r_acc_cnt <= '0;
            r_del_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_val <= 1'b1;
                r_out_msg <= w_grant_msg;
                r_out_src <= w_grant_idx;
                r_ptr     <= (w_grant_idx == LAST) ? '0 : w_grant_idx + PTR_ONE;
            end else if (w_deliver) begin
                r_out_val <= 1'b0;
            end

            if (w_accept && (r_acc_cnt != NMSGS)) begin
                r_acc_cnt <= r_acc_cnt + CNT_ONE;
            end

            if (w_deliver && (r_del_cnt != NMSGS)) begin
                r_del_cnt <= r_del_cnt + CNT_ONE;
            end

            // Sticky: set on the handshake that brings del_cnt to p_nmsgs.
            if (w_deliver && (r_del_cnt == NMSGS - CNT_ONE)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign bus.req_rdy = w_req_rdy;
    assign bus.out_val = r_out_val;
    assign bus.out_msg = r_out_msg;
    assign bus.out_src = r_out_src;
    assign bus.done    = r_done;

`ifdef VALRDY_RR_ARBITER_CNT_EN
    for (genvar gi = 0; gi < p_nreqs; gi++) begin : g_gcnt
        logic [15:0] r_gcnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_gcnt <= '0;
            end else if (bus.req_val[gi] && w_req_rdy[gi] && (r_gcnt != 16'hFFFF)) begin
                r_gcnt <= r_gcnt + 16'd1;
            end
        end

        assign grant_cnt[gi*16 +: 16] = r_gcnt;
    end
`endif

endmodule

// File: tb/tb_valrdy_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_valrdy_rr_arbiter
//   Directed bench for valrdy_rr_arbiter (p_width=16, p_nreqs=4, p_nmsgs=8).
//   Each accepted request pushes its expected {src, msg} into a scoreboard;
//   each output handshake pops and compares. Ready, out_val and done are
//   compared every cycle against a small bench-side model.
// ----------------------------------------------------------------------------
module tb_valrdy_rr_arbiter;
    localparam int NMSGS = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    valrdy_rr_arbiter_if #(.p_width(16), .p_nreqs(4)) bus();

`ifdef VALRDY_RR_ARBITER_CNT_EN
    logic [63:0] grant_cnt;
`endif

    valrdy_rr_arbiter #(
        .p_width (16),
        .p_nreqs (4),
        .p_nmsgs (NMSGS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef VALRDY_RR_ARBITER_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int          checks   = 0;
    int          failures = 0;
    logic [17:0] sb[$];
    logic        m_oval   = 1'b0;
    int          m_del    = 0;
    logic        m_done   = 1'b0;
    logic [15:0] msgs[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already set; samples at posedge+2,
    // then advances to the next posedge+1. exp_g = expected grant, -1 = none.
    task automatic step(input int exp_g);
        logic [3:0]  exp_rdy;
        logic [17:0] ent;
        logic        drain;
        bus.req_msg = {msgs[3], msgs[2], msgs[1], msgs[0]};
        #1;
        exp_rdy = (exp_g >= 0) ? 4'(1 << exp_g) : 4'b0000;
        check("req_rdy", 32'(bus.req_rdy), 32'(exp_rdy));
        check("out_val", 32'(bus.out_val), 32'(m_oval));
        check("done",    32'(bus.done),    32'(m_done));
        drain = bus.out_val && bus.out_rdy;
        if (drain) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow observed=out_handshake expected=no_output");
            end else begin
                ent = sb.pop_front();
                $display("out src=%0d msg=%h", bus.out_src, bus.out_msg);
                check("out_src", 32'(bus.out_src), 32'(ent[17:16]));
                check("out_msg", 32'(bus.out_msg), 32'(ent[15:0]));
            end
        end
        if (exp_g >= 0) begin
            sb.push_back({exp_g[1:0], msgs[exp_g]});
            m_oval = 1'b1;
        end else if (drain) begin
            m_oval = 1'b0;
        end
        if (drain) begin
            m_del++;
            m_done = (m_del >= NMSGS);
        end
        @(posedge clk);
        #1;
    endtask

    // Asserts reset asynchronously, checks that state clears at once,
    // then releases it on the next posedge+1.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_out_val", 32'(bus.out_val), 32'd0);
        check("rst_out_msg", 32'(bus.out_msg), 32'd0);
        check("rst_out_src", 32'(bus.out_src), 32'd0);
        check("rst_done",    32'(bus.done),    32'd0);
        check("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
        sb.delete();
        m_oval = 1'b0;
        m_del  = 0;
        m_done = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bus.req_val = 4'hF;
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) msgs[i] = 16'h0;
        bus.req_msg = '0;
        #2;
        do_reset();

        // Single requester: req 2 sends 1..5, ptr ends at 3.
        bus.out_rdy = 1'b1;
        bus.req_val = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            msgs[2] = 16'(k);
            step(2);
        end
        bus.req_val = 4'b0000;
        step(-1);

        // Wrap: ptr=3, only req 0 and 3 valid -> 3, 0, 3 (reaches 8 accepts).
        msgs[0] = 16'hA000;
        msgs[3] = 16'hA003;
        bus.req_val = 4'b1001;
        step(3);
        step(0);
        step(3);
        bus.req_val = 4'b0000;
        step(-1);
        // Closed after 8 accepts; done is high the cycle after 8th drain.
        bus.req_val = 4'hF;
        step(-1);
        step(-1);

        // All four valid continuously: 0,1,2,3,0,1,2,3 at one per cycle.
        do_reset();
        bus.req_val = 4'hF;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) msgs[i] = 16'(16'h1000 * (k + 1) + i);
            step(k % 4);
        end
        step(-1);
        step(-1);
`ifdef VALRDY_RR_ARBITER_CNT_EN
        for (int i = 0; i < 4; i++) begin
            check("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'd2);
        end
`endif

        // Backpressure: BEEF from req 1 held for 3 cycles, then req 2 next.
        do_reset();
        bus.req_val = 4'b0010;
        msgs[1] = 16'hBEEF;
        msgs[2] = 16'h2222;
        step(1);
        bus.out_rdy = 1'b0;
        bus.req_val = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            step(-1);
            check("bp_out_msg", 32'(bus.out_msg), 32'hBEEF);
            check("bp_out_src", 32'(bus.out_src), 32'd1);
        end
        bus.out_rdy = 1'b1;
        step(2);
        bus.req_val = 4'b0000;
        step(-1);

        // Reset mid-stream with a buffered message, then a full fresh run
        // (needs the accept counter to have restarted from 0).
        msgs[3] = 16'h3333;
        bus.req_val = 4'b1000;
        step(3);
        check("pre_rst_out_val", 32'(bus.out_val), 32'd1);
        bus.req_val = 4'hF;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) msgs[i] = 16'(16'h5000 + 16'h10 * k + i);
            step(k % 4);
        end
        step(-1);
        step(-1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
